// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory arbiter slice.
package mem_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 64;
  localparam int unsigned DefAddr  = $clog2(DefDepth);

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector; on a tie the requester that did
// not win last time is picked.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |req_i;
    if (req_i == 2'b11) begin
      grant_idx_o = ~last_grant_i;
    end else begin
      grant_idx_o = req_i[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that sequences single transfers into a
// valid/ready memory port, with a bounded wait and per-requester error flag.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned ADDR    = $clog2(DEPTH),
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  input  logic             req0_wr_rd_i,
  input  logic [ADDR-1:0]  req0_addr_i,
  input  logic [WIDTH-1:0] req0_wdata_i,
  output logic             req0_ready_o,
  output logic [WIDTH-1:0] req0_rdata_o,
  output logic             req0_err_o,
  input  logic             req1_valid_i,
  input  logic             req1_wr_rd_i,
  input  logic [ADDR-1:0]  req1_addr_i,
  input  logic [WIDTH-1:0] req1_wdata_i,
  output logic             req1_ready_o,
  output logic [WIDTH-1:0] req1_rdata_o,
  output logic             req1_err_o,
  output logic             mem_valid_o,
  output logic             mem_wr_rd_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  input  logic             mem_ready_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic                    gnt_q;
  logic                    last_q;
  logic                    mem_valid_q;
  logic                    mem_wr_rd_q;
  logic [ADDR-1:0]         mem_addr_q;
  logic [WIDTH-1:0]        mem_wdata_q;
  logic [1:0]              rdy_q;
  logic [1:0]              err_q;
  logic [1:0][WIDTH-1:0]   rdata_q;

  logic pick_valid;
  logic pick_idx;

  rr_pick2 u_pick (
    .req_i         ({req1_valid_i, req0_valid_i}),
    .last_grant_i  (last_q),
    .grant_valid_o (pick_valid),
    .grant_idx_o   (pick_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdy_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            gnt_q       <= pick_idx;
            mem_valid_q <= 1'b1;
            mem_wr_rd_q <= pick_idx ? req1_wr_rd_i : req0_wr_rd_i;
            mem_addr_q  <= pick_idx ? req1_addr_i  : req0_addr_i;
            mem_wdata_q <= pick_idx ? req1_wdata_i : req0_wdata_i;
            cnt_q       <= '0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          // A ready on the final allowed edge still counts as success.
          if (mem_ready_i) begin
            mem_valid_q   <= 1'b0;
            rdy_q[gnt_q]  <= 1'b1;
            err_q[gnt_q]  <= 1'b0;
            if (mem_wr_rd_q == RD) begin
              rdata_q[gnt_q] <= mem_rdata_i;
            end
            state_q <= StDone;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            mem_valid_q  <= 1'b0;
            rdy_q[gnt_q] <= 1'b1;
            err_q[gnt_q] <= 1'b1;
            state_q      <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          rdy_q   <= '0;
          err_q   <= '0;
          last_q  <= gnt_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req0_ready_o = rdy_q[0];
  assign req1_ready_o = rdy_q[1];
  assign req0_err_o   = err_q[0];
  assign req1_err_o   = err_q[1];
  assign req0_rdata_o = rdata_q[0];
  assign req1_rdata_o = rdata_q[1];
  assign mem_valid_o  = mem_valid_q;
  assign mem_wr_rd_o  = mem_wr_rd_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// reference: a behavioural memory, a scoreboard and a round-robin grant model.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int W  = DefWidth;
  localparam int D  = DefDepth;
  localparam int A  = $clog2(D);
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0_valid, r0_wr, r0_ready, r0_err;
  logic [A-1:0] r0_addr;
  logic [W-1:0] r0_wdata, r0_rdata;
  logic         r1_valid, r1_wr, r1_ready, r1_err;
  logic [A-1:0] r1_addr;
  logic [W-1:0] r1_wdata, r1_rdata;
  logic         mem_valid_o, mem_wr_rd_o, mem_ready_i;
  logic [A-1:0] mem_addr_o;
  logic [W-1:0] mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .DEPTH(D), .ADDR(A), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (r0_valid),
    .req0_wr_rd_i (r0_wr),
    .req0_addr_i  (r0_addr),
    .req0_wdata_i (r0_wdata),
    .req0_ready_o (r0_ready),
    .req0_rdata_o (r0_rdata),
    .req0_err_o   (r0_err),
    .req1_valid_i (r1_valid),
    .req1_wr_rd_i (r1_wr),
    .req1_addr_i  (r1_addr),
    .req1_wdata_i (r1_wdata),
    .req1_ready_o (r1_ready),
    .req1_rdata_o (r1_rdata),
    .req1_err_o   (r1_err),
    .mem_valid_o  (mem_valid_o),
    .mem_wr_rd_o  (mem_wr_rd_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ready_i  (mem_ready_i)
  );

  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [W-1:0] init_val(input int i);
    return W'(i * 4951 + 11339);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural memory: ready is raised lat+2 cycles into a valid phase.
  logic [W-1:0] tbmem [D];
  int mem_lat = 0;
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < D; i++) tbmem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (mem_valid_o) wcnt = wcnt + 1;
      else wcnt = 0;
      mem_ready_i = mem_valid_o && (wcnt == mem_lat + 2);
      if (mem_ready_i) begin
        if (mem_wr_rd_o == WR) tbmem[mem_addr_o] = mem_wdata_o;
        mem_rdata_i = tbmem[mem_addr_o];
      end else begin
        mem_rdata_i = W'($urandom);
      end
    end
  end

  int p0 = 0, p1 = 0, vrun = 0, last_run = 0;
  always @(negedge clk) begin
    if (r0_ready) p0 <= p0 + 1;
    if (r1_ready) p1 <= p1 + 1;
    if (mem_valid_o) vrun <= vrun + 1;
    else begin
      if (vrun != 0) last_run <= vrun;
      vrun <= 0;
    end
  end

  logic [W-1:0] ref_mem [D];
  logic [W-1:0] exp_rd [2];
  int last_g = 1;

  task automatic drive(input int idx, input logic v, input logic wr, input logic [A-1:0] a,
                       input logic [W-1:0] d);
    if (idx == 0) begin
      r0_valid = v; r0_wr = wr; r0_addr = a; r0_wdata = d;
    end else begin
      r1_valid = v; r1_wr = wr; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic do_txn(input int idx, input logic wr, input logic [A-1:0] a,
                        input logic [W-1:0] d, input int lat);
    int t, op0, op1;
    logic got, exp_err;
    logic [W-1:0] other_rd;
    other_rd = (idx == 0) ? r1_rdata : r0_rdata;
    op0 = p0;
    op1 = p1;
    mem_lat = lat;
    exp_err = (lat + 2 > TO);
    @(negedge clk);
    drive(idx, 1'b1, wr, a, d);
    t = 0;
    got = 1'b0;
    while (!got && t < 200) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        chk("mem_valid", 64'(mem_valid_o), 64'(1));
        chk("mem_addr", 64'(mem_addr_o), 64'(a));
        chk("mem_wr_rd", 64'(mem_wr_rd_o), 64'(wr));
        chk("mem_wdata", 64'(mem_wdata_o), 64'(d));
      end
      got = (idx == 0) ? r0_ready : r1_ready;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $error("FAIL ready_wait: observed no pulse expected pulse within 200 cycles");
    end else begin
      if (!wr && !exp_err) exp_rd[idx] = ref_mem[a];
      if (wr && !exp_err) ref_mem[a] = d;
      chk("latency", 64'(t), exp_err ? 64'(TO + 1) : 64'(lat + 3));
      chk("err", 64'((idx == 0) ? r0_err : r1_err), 64'(exp_err));
      chk("rdata", 64'((idx == 0) ? r0_rdata : r1_rdata), 64'(exp_rd[idx]));
      chk("other_ready", 64'((idx == 0) ? r1_ready : r0_ready), 64'(0));
      chk("other_rdata", 64'((idx == 0) ? r1_rdata : r0_rdata), 64'(other_rd));
      last_g = idx;
    end
    drive(idx, 1'b0, wr, a, d);
    @(negedge clk);
    chk("ready_one_cycle", 64'({r1_ready, r0_ready}), 64'(0));
    chk("err_cleared", 64'({r1_err, r0_err}), 64'(0));
    @(negedge clk);
    chk("valid_cycles", 64'(last_run), exp_err ? 64'(TO) : 64'(lat + 2));
    chk("pulses0", 64'(p0 - op0), 64'(idx == 0));
    chk("pulses1", 64'(p1 - op1), 64'(idx == 1));
  endtask

  // Both requesters hold read requests until n completions have been seen.
  task automatic run_both(input logic [A-1:0] a0, input logic [A-1:0] a1, input int n,
                          input int lat);
    int t, cnt, nxt;
    mem_lat = lat;
    exp_rd[0] = ref_mem[a0];
    exp_rd[1] = ref_mem[a1];
    nxt = 1 - last_g;
    cnt = 0;
    t = 0;
    @(negedge clk);
    drive(0, 1'b1, RD, a0, '0);
    drive(1, 1'b1, RD, a1, '0);
    while (cnt < n && t < 400) begin
      @(negedge clk);
      t++;
      if (r0_ready || r1_ready) begin
        chk("both_grant", 64'({r1_ready, r0_ready}), (nxt == 1) ? 64'(2) : 64'(1));
        chk("both_addr", 64'(mem_addr_o), (nxt == 1) ? 64'(a1) : 64'(a0));
        chk("both_rdata", 64'((nxt == 1) ? r1_rdata : r0_rdata), 64'(exp_rd[nxt]));
        chk("both_err", 64'({r1_err, r0_err}), 64'(0));
        last_g = nxt;
        nxt = 1 - nxt;
        cnt++;
        if (cnt == n) begin
          drive(0, 1'b0, RD, a0, '0);
          drive(1, 1'b0, RD, a1, '0);
        end
      end
    end
    if (cnt < n) begin
      n_cmp++;
      n_fail++;
      $error("FAIL both_wait: observed %0d pulses expected %0d", cnt, n);
      drive(0, 1'b0, RD, a0, '0);
      drive(1, 1'b0, RD, a1, '0);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int op0, op1, s;
    for (int i = 0; i < D; i++) ref_mem[i] = init_val(i);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    rst = 1'b1;
    drive(0, 1'b0, RD, '0, '0);
    drive(1, 1'b0, RD, '0, '0);
    repeat (2) @(negedge clk);
    chk("reset_outs", {4'd0, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o, r0_ready,
        r0_rdata, r0_err, r1_ready, r1_rdata, r1_err}, 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write then read back through requester 0.
    do_txn(0, WR, 6'd10, 16'hA5A5, 0);
    do_txn(0, RD, 6'd10, 16'h0000, 0);
    chk("t1_readback", 64'(r0_rdata), 64'(16'hA5A5));

    // Requester 1 goes last so the tie sequence starts with requester 0.
    do_txn(1, RD, 6'd3, 16'h0000, 1);
    op0 = p0;
    op1 = p1;
    run_both(6'd20, 6'd21, 4, 0);
    chk("t2_pulses0", 64'(p0 - op0), 64'(2));
    chk("t2_pulses1", 64'(p1 - op1), 64'(2));

    // Memory never answers, then answers on the last allowed edge, then one late.
    do_txn(1, RD, 6'd5, 16'h0000, 1);
    do_txn(1, RD, 6'd6, 16'h0000, 100);
    do_txn(1, RD, 6'd7, 16'h0000, 14);
    do_txn(0, RD, 6'd8, 16'h0000, 14);
    do_txn(0, WR, 6'd9, 16'h1234, 15);
    do_txn(0, RD, 6'd9, 16'h0000, 0);

    // Asynchronous reset in the middle of a stalled transfer.
    mem_lat = 100;
    @(negedge clk);
    drive(0, 1'b1, RD, 6'd40, '0);
    repeat (4) @(negedge clk);
    chk("rst_pre_busy", 64'(mem_valid_o), 64'(1));
    op0 = p0;
    op1 = p1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_outs", {4'd0, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o, r0_ready,
        r0_rdata, r0_err, r1_ready, r1_rdata, r1_err}, 64'(0));
    @(negedge clk);
    drive(0, 1'b0, RD, 6'd40, '0);
    @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_g = 1;
    repeat (20) @(negedge clk);
    chk("rst_no_pulse0", 64'(p0), 64'(op0));
    chk("rst_no_pulse1", 64'(p1), 64'(op1));
    run_both(6'd30, 6'd31, 2, 0);

    // Burst of writes via requester 1, read back via requester 0.
    s = p0 + p1;
    for (int i = 10; i < 20; i++) do_txn(1, WR, A'(i), W'($urandom), int'($urandom_range(0, 3)));
    for (int i = 10; i < 20; i++) do_txn(0, RD, A'(i), '0, int'($urandom_range(0, 3)));
    chk("t6_pulses", 64'(p0 + p1 - s), 64'(20));

    // Random single transfers, including latencies past the timeout.
    for (int k = 0; k < 12; k++) begin
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), A'($urandom_range(0, D - 1)),
             W'($urandom), int'($urandom_range(0, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port `memory` block. It uses the `memory` handshake: valid_i / wr_rd / addr_i / write_i going in, ready_o / read_o coming back.
- Each requester sees a simple request/acknowledge port. The arbiter latches one request, drives the memory until the memory accepts it, and returns read data or an error to the owning requester.
- Placed between bus masters (DMA, video fetch) and the memory instance.

Parameters:
- WIDTH, 16, data width; must match `memory` WIDTH.
- DEPTH, 64, memory depth.
- ADDR, $clog2(DEPTH), address width.
- TIMEOUT, 16, maximum cycles in BUSY waiting for mem_ready_i before aborting; legal range is 2 or more.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req0_valid_i  in  1  requester 0 request.
- req0_wr_rd_i  in  1  1 = write, 0 = read.
- req0_addr_i  in  ADDR  requester 0 address.
- req0_wdata_i  in  WIDTH  requester 0 write data.
- req0_ready_o  out  1  one-cycle completion pulse.
- req0_rdata_o  out  WIDTH  read data; valid while req0_ready_o is high.
- req0_err_o  out  1  timeout flag; valid while req0_ready_o is high.
- req1_*  (same seven signals as req0_*)  requester 1.
- mem_valid_o  out  1  drives memory valid_i.
- mem_wr_rd_o  out  1  drives memory wr_rd.
- mem_addr_o  out  ADDR  drives memory addr_i.
- mem_wdata_o  out  WIDTH  drives memory write_i.
- mem_rdata_i  in  WIDTH  from memory read_o.
- mem_ready_i  in  1  from memory ready_o.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - State goes to IDLE.
  - All outputs are 0: mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o, every reqN_ready_o, reqN_rdata_o and reqN_err_o.
  - last_grant=1, so requester 0 wins the first tie.
  - Timeout counter is cleared.
- Asserting reset mid-transaction drops mem_valid_o immediately (combinationally with the async clear). No ready_o pulse is ever issued for the aborted transaction.
- FSM states are IDLE, BUSY and DONE. All outputs are registered.
- IDLE:
  - If any reqN_valid_i is high at a clock edge, grant a requester:
    - If only one is requesting, it wins.
    - If both are requesting, the one that is not last_grant wins.
  - On the grant, latch wr_rd, addr and wdata into mem_* and set mem_valid_o=1. Clear the counter and go to BUSY.
- BUSY:
  - mem_* stays stable and mem_valid_o stays at 1.
  - A transfer completes at the edge where mem_valid_o=1 and mem_ready_i=1:
    - On a read, capture mem_rdata_i into the granted requester's rdata_o.
    - Set err=0, drop mem_valid_o and go to DONE.
  - Otherwise the counter increments. At the edge where it reaches TIMEOUT-1 with no ready:
    - drop mem_valid_o;
    - set the granted requester's err_o=1;
    - leave rdata_o unchanged;
    - go to DONE.
  - If ready and timeout coincide on the same edge, ready wins and err=0.
- DONE:
  - The granted requester's ready_o=1 for exactly one cycle. err_o is valid in that cycle.
  - last_grant is updated to that requester, and the FSM returns to IDLE.
  - err_o returns to 0 on the next cycle.
  - rdata_o holds its value until the next completed read for that requester.
- The ungranted requester's outputs never change during another requester's transaction.
- Latency: a request sampled at edge N drives mem_valid_o from cycle N+1.
  - With zero-wait memory (ready at edge N+2), ready_o is high in cycle N+2→N+3.
  - Minimum turnaround is 3 cycles per transaction.
- Requester protocol:
  - Hold valid, wr_rd, addr and wdata stable until ready_o is seen, then drop valid or present the next request.
  - Fields are latched at grant, so if a requester drops valid early the latched transaction still completes and ready_o still pulses.
- Fairness:
  - While both requesters hold valid, grants alternate 0,1,0,1 with no starvation.
  - A requester that re-asserts valid in the same IDLE cycle in which the other requester is waiting loses that arbitration.
- Width rules: the counter is $clog2(TIMEOUT+1) bits. Addresses pass through unmodified, with no range check.

Decomposition:
- Shared package/header mem_pkg holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - WR=1'b1 and RD=1'b0;
  - the default WIDTH/DEPTH/ADDR.
- One natural sub-module, rr_pick2: a combinational 2-way round-robin selector. Inputs are the two requests and last_grant; outputs are grant_valid and grant_idx.
- The timeout counter and FSM stay in mem_arbiter.

Test Plan:
1. Reset, then req0 writes addr=10, data=16'hA5A5 with memory ready one cycle after valid.
   - mem_addr_o=10, mem_wdata_o=A5A5, mem_wr_rd_o=1.
   - req0_ready_o pulses once with err=0; then read of addr 10 returns req0_rdata_o=A5A5.
2. req0 and req1 assert valid together, both reading addr 20 and 21, held for 4 transactions.
   - Grant order 0,1,0,1; each ready_o pulses exactly twice, and mem_addr_o alternates 20,21.
3. Memory ready held low for a TIMEOUT=16 request.
   - mem_valid_o is high 16 cycles then drops; req1_err_o=1 coincides with req1_ready_o; rdata is unchanged.
4. Memory ready arrives on exactly the timeout edge.
   - Completion with err=0, and read data is captured.
5. rst_i asserted asynchronously mid-BUSY, off a clock edge.
   - mem_valid_o=0 immediately and all outputs are 0; no ready_o pulse follows.
   - The next request after release is granted to req0 on a tie.
6. Sequential writes to addr 10..19 with random data via req1, then reads of 10..19 via req0.
   - Every read matches the scoreboard; 20 ready pulses total; the counter never overflows.
